// File: rtl/alu4_pkg.sv
// rtl/alu4_pkg.sv - shared types and constants for the two-requester ALU arbiter
package alu4_pkg;

  localparam int N_REQ  = 2;
  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_NOT = 3'b010,
    ALU_AND = 3'b011,
    ALU_OR  = 3'b100,
    ALU_XOR = 3'b101,
    ALU_SLT = 3'b110,
    ALU_EQ  = 3'b111
  } alu_op_t;

  typedef struct packed {
    logic [DATA_W-1:0] out;
    logic              zero;
    logic              carry;
    logic              ovf;
  } alu_res_t;

  // State value doubles as the round-robin pointer: the requester favoured on a tie
  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu4_share_arb_if.sv
// rtl/alu4_share_arb_if.sv - request/response channels of both requesters
interface alu4_share_arb_if;
  import alu4_pkg::*;

  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0]             req_ready;
  logic [N_REQ-1:0][2:0]        req_op;
  logic [N_REQ-1:0][DATA_W-1:0] req_a;
  logic [N_REQ-1:0][DATA_W-1:0] req_b;
  logic [N_REQ-1:0]             rsp_valid;
  logic [N_REQ-1:0]             rsp_ready;
  logic [N_REQ-1:0][DATA_W-1:0] rsp_out;
  logic [N_REQ-1:0]             rsp_zero;
  logic [N_REQ-1:0]             rsp_carry;
  logic [N_REQ-1:0]             rsp_ovf;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_out, rsp_zero, rsp_carry, rsp_ovf
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_out, rsp_zero, rsp_carry, rsp_ovf
  );

endinterface

// File: rtl/alu4_core.sv
// rtl/alu4_core.sv - combinational 4-bit two's-complement ALU with zero/carry/overflow
module alu4_core
  import alu4_pkg::*;
(
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output alu_res_t          res
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    res = '0;
    case (op)
      ALU_ADD: begin
        res.out   = sum[DATA_W-1:0];
        res.carry = sum[DATA_W];
        res.ovf   = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      // carry out of the subtraction reads as a borrow
      ALU_SUB: begin
        res.out   = diff[DATA_W-1:0];
        res.carry = diff[DATA_W];
        res.ovf   = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_NOT: res.out = ~a;
      ALU_AND: res.out = a & b;
      ALU_OR:  res.out = a | b;
      ALU_XOR: res.out = a ^ b;
      ALU_SLT: res.out = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_EQ:  res.out = {{(DATA_W-1){1'b0}}, (a == b)};
      default: res.out = '0;
    endcase
    res.zero = (res.out == '0);
  end

endmodule

// File: rtl/alu4_share_arb.sv
// rtl/alu4_share_arb.sv - round-robin sharing of one ALU between two requesters
module alu4_share_arb
  import alu4_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  alu4_share_arb_if.slave             bus,
  output logic [N_REQ-1:0][CNT_W-1:0] done_cnt
);

  arb_state_t       state;
  arb_state_t       state_n;
  logic [N_REQ-1:0] elig;
  logic             winner;
  logic             grant;
  alu_op_t          alu_op;
  alu_res_t         alu_res;

  // A full slot being drained this cycle can be refilled in the same cycle
  assign elig = bus.req_valid & (~bus.rsp_valid | bus.rsp_ready);

  always_comb begin
    state_n       = state;
    winner        = 1'b0;
    bus.req_ready = '0;
    case (elig)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = (state == PRI1);
      default: winner = 1'b0;
    endcase
    grant = (|elig) && rst_n;
    if (grant) begin
      bus.req_ready[winner] = 1'b1;
      state_n = winner ? PRI0 : PRI1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PRI0;
    else        state <= state_n;
  end

  assign alu_op = alu_op_t'(bus.req_op[winner]);

  alu4_core u_alu (
    .op  (alu_op),
    .a   (bus.req_a[winner]),
    .b   (bus.req_b[winner]),
    .res (alu_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= '0;
      bus.rsp_out   <= '0;
      bus.rsp_zero  <= '0;
      bus.rsp_carry <= '0;
      bus.rsp_ovf   <= '0;
      done_cnt      <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req_ready[i]) begin
          bus.rsp_valid[i] <= 1'b1;
          bus.rsp_out[i]   <= alu_res.out;
          bus.rsp_zero[i]  <= alu_res.zero;
          bus.rsp_carry[i] <= alu_res.carry;
          bus.rsp_ovf[i]   <= alu_res.ovf;
          if (done_cnt[i] != {CNT_W{1'b1}})
            done_cnt[i] <= done_cnt[i] + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (bus.rsp_ready[i]) begin
          bus.rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu4_share_arb.sv
// tb/tb_alu4_share_arb.sv - randomized and directed bench for alu4_share_arb
module tb_alu4_share_arb;
  import alu4_pkg::*;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N_REQ-1:0][CNT_W-1:0] done_cnt;

  alu4_share_arb_if bus ();

  alu4_share_arb #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one buffered {out,zero,carry,ovf} per requester
  bit         m_valid[2];
  logic [6:0] m_res[2];
  int         m_cnt[2];
  int         m_prio;
  bit         last_g[2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0;
      m_res[i]   = '0;
      m_cnt[i]   = 0;
      last_g[i]  = 0;
    end
    m_prio = 0;
  endfunction

  function automatic logic [6:0] ref_alu(int op, int a, int b);
    int sa, sb, r, o;
    bit c, v;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    c = 0; v = 0; o = 0;
    case (op)
      0: begin r = a + b; c = (r > 15); o = r % 16; v = (sa + sb > 7) || (sa + sb < -8); end
      1: begin r = a - b; c = (r < 0); o = (r + 16) % 16; v = (sa - sb > 7) || (sa - sb < -8); end
      2: o = 15 - a;
      3: o = a & b;
      4: o = a | b;
      5: o = a ^ b;
      6: o = (sa < sb) ? 1 : 0;
      default: o = (a == b) ? 1 : 0;
    endcase
    return {4'(o), (o == 0), c, v};
  endfunction

  // Check every output against the model at the falling edge, then advance the model across the rising edge
  task automatic cycle();
    bit         el[2];
    int         g;
    logic [1:0] rr;
    logic [6:0] res;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rsp_valid%0d", i), bus.rsp_valid[i], m_valid[i]);
      check($sformatf("rsp_out%0d", i),   bus.rsp_out[i],   m_res[i][6:3]);
      check($sformatf("rsp_zero%0d", i),  bus.rsp_zero[i],  m_res[i][2]);
      check($sformatf("rsp_carry%0d", i), bus.rsp_carry[i], m_res[i][1]);
      check($sformatf("rsp_ovf%0d", i),   bus.rsp_ovf[i],   m_res[i][0]);
      check($sformatf("done_cnt%0d", i),  done_cnt[i],      m_cnt[i]);
    end
    rr = bus.rsp_ready;
    for (int i = 0; i < 2; i++) el[i] = bus.req_valid[i] && (!m_valid[i] || rr[i]);
    g = -1;
    if (el[0] && el[1]) g = m_prio;
    else if (el[0])     g = 0;
    else if (el[1])     g = 1;
    check("req_ready", bus.req_ready, (g < 0) ? 0 : (1 << g));
    res = '0;
    if (g >= 0) res = ref_alu(int'(bus.req_op[g]), int'(bus.req_a[g]), int'(bus.req_b[g]));
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      last_g[i] = (g == i);
      if (g == i) begin
        m_valid[i] = 1;
        m_res[i]   = res;
        if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
      end else if (rr[i]) begin
        m_valid[i] = 0;
      end
    end
    if (g >= 0) m_prio = 1 - g;
  endtask

  task automatic drive_random();
    for (int i = 0; i < 2; i++) begin
      if (!(bus.req_valid[i] && !last_g[i])) begin
        bus.req_valid[i] = ($urandom_range(0, 3) != 0);
        bus.req_op[i]    = 3'($urandom());
        bus.req_a[i]     = 4'($urandom());
        bus.req_b[i]     = 4'($urandom());
      end
      bus.rsp_ready[i] = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic run_op(int i, alu_op_t op, int a, int b, int e_out, int e_z, int e_c, int e_v);
    bus.req_valid    = '0;
    bus.req_valid[i] = 1'b1;
    bus.req_op[i]    = op;
    bus.req_a[i]     = 4'(a);
    bus.req_b[i]     = 4'(b);
    bus.rsp_ready    = 2'b11;
    #1;
    check($sformatf("%s_ready", op.name()), bus.req_ready[i], 1);
    cycle();
    bus.req_valid = '0;
    check($sformatf("%s_valid", op.name()), bus.rsp_valid[i], 1);
    check($sformatf("%s_out", op.name()),   bus.rsp_out[i],   e_out);
    check($sformatf("%s_zero", op.name()),  bus.rsp_zero[i],  e_z);
    check($sformatf("%s_carry", op.name()), bus.rsp_carry[i], e_c);
    check($sformatf("%s_ovf", op.name()),   bus.rsp_ovf[i],   e_v);
  endtask

  initial begin
    int c0, c1;
    bus.req_valid = 2'b11;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_out",   bus.rsp_out, 0);
    check("rst_done_cnt",  done_cnt, 0);
    bus.req_valid = '0;
    rst_n = 1'b1;

    run_op(0, ALU_ADD, 7, 1, 4'b1000, 0, 0, 1);
    check("add_done_cnt0", done_cnt[0], 1);
    run_op(1, ALU_SUB, 0, 1, 4'b1111, 0, 1, 0);
    run_op(1, ALU_SUB, 8, 1, 4'b0111, 0, 0, 1);
    run_op(0, ALU_SLT, 15, 1, 1, 0, 0, 0);
    run_op(0, ALU_EQ,  5, 5, 1, 0, 0, 0);
    run_op(0, ALU_XOR, 5, 5, 0, 1, 0, 0);
    run_op(0, ALU_NOT, 0, 0, 4'b1111, 0, 0, 0);

    // Contention: both always eligible must alternate
    c0 = m_cnt[0];
    c1 = m_cnt[1];
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    repeat (6) cycle();
    check("cont_cnt0", done_cnt[0], c0 + 3);
    check("cont_cnt1", done_cnt[1], c1 + 3);

    // Backpressure on slot 0 leaves requester 1 winning every cycle
    bus.rsp_ready = 2'b10;
    repeat (4) cycle();
    check("bp_ready", bus.req_ready, 2'b10);
    check("bp_frozen_valid", bus.rsp_valid[0], 1);
    bus.rsp_ready = 2'b11;
    #1;
    check("bp_refill_ready", bus.req_ready, 2'b01);
    cycle();

    repeat (1500) begin
      drive_random();
      cycle();
    end
    check("sat_cnt0", done_cnt[0], CNT_MAX);

    // Reset landing between a grant and its response edge
    bus.req_valid = 2'b01;
    bus.req_op[0] = ALU_ADD;
    bus.rsp_ready = 2'b11;
    #1;
    check("mid_grant", bus.req_ready, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rsp_valid", bus.rsp_valid, 0);
    check("mid_done_cnt",  done_cnt, 0);
    check("mid_req_ready", bus.req_ready, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    check("post_rst_grant", bus.req_ready, 2'b01);
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu4_share_arb.md
Name: alu4_share_arb

Overview:
- Shares one 4-bit combinational ALU (add/sub/not/and/or/xor/slt/eq) between two requesters, each with its own valid/ready request channel and response channel.
- Arbitration is round-robin. Each requester has a one-entry registered response buffer holding the result and the zero/carry/overflow flags until the requester accepts it.
- Sits between the two operand sources and the shared ALU. Each requester also gets a saturating count of completed operations.

Parameters:
CNT_W, 8, width of per-requester completion counters (saturating)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  per-requester request valid (bit i = requester i)
req_ready  out  2  per-requester request accepted this cycle
req_op  in  2x3  per-requester opcode
req_a  in  2x4  per-requester signed operand A
req_b  in  2x4  per-requester signed operand B
rsp_valid  out  2  response buffer i holds a result
rsp_ready  in  2  requester i consumes response
rsp_out  out  2x4  buffered result
rsp_zero  out  2  buffered zero flag
rsp_carry  out  2  buffered carry flag
rsp_ovf  out  2  buffered overflow flag
done_cnt  out  2xCNT_W  completed-op counters

Behaviour:
- Reset (rst_n low, async): rsp_valid=0, rsp_out/flags=0, done_cnt=0, rr_ptr=0 (requester 0 has priority). req_ready is combinational and is 0 while in reset.
- Eligibility: requester i is eligible when req_valid[i] is high and its slot is free. A slot is free when rsp_valid[i]=0, or rsp_valid[i]=1 and rsp_ready[i]=1 in the same cycle (drain-and-refill).
- Grant: at most one grant per cycle.
  - If only one requester is eligible, it wins.
  - If both are eligible, the winner is the requester selected by rr_ptr.
  - req_ready = one-hot grant (combinational).
  - On a grant, rr_ptr <= ~winner.
  - rr_ptr is unchanged in cycles with no grant.
- Grant FSM has two states, PRI0 and PRI1 (rr_ptr value).
  - PRI0 moves to PRI1 when requester 0 is granted.
  - PRI1 moves to PRI0 when requester 1 is granted.
  - Otherwise the state holds.
- Execute: the winner's op/a/b drive the ALU in the grant cycle. The result and flags are registered into slot[winner] at the next edge and rsp_valid[winner] <= 1. Latency from accept to rsp_valid is 1 cycle.
- Drain: rsp_valid[i] & rsp_ready[i] with no new grant to i sets rsp_valid[i] <= 0. Data registers hold their last value.
- Response stability: while rsp_valid[i]=1 and rsp_ready[i]=0, slot i is frozen.
- Held requests: a requester that is not granted must hold valid/op/a/b stable. The block does not sample operands without a grant.
- ALU rules (4-bit, two's complement):
  - 000 add: {carry,out} = 5-bit unsigned A+B; ovf = (A3==B3)&&(out3!=A3).
  - 001 sub: {carry,out} = 5-bit unsigned A-B, so carry=1 means borrow; ovf = (A3!=B3)&&(out3!=A3).
  - 010 ~A; 011 A&B; 100 A|B; 101 A^B.
  - 110 out = (signed A < signed B) ? 1 : 0.
  - 111 out = (A==B) ? 1 : 0.
  - For ops 010-111, carry=0 and ovf=0.
  - zero = (out==0) for all ops.
- done_cnt[i] increments on each grant to i and saturates at all-ones.
- Reset mid-operation: an in-flight grant is discarded and buffered results are lost. After reset, requester 0 has priority.
- Starvation: with both requesters continuously eligible, grants strictly alternate.

Decomposition:
- Package alu4_pkg:
  - op enum ALU_ADD..ALU_EQ (3-bit).
  - Struct alu_res_t {out[3:0], zero, carry, ovf}.
  - Constants N_REQ=2, DATA_W=4.
- Sub-module alu4_core: purely combinational, (op,a,b) -> alu_res_t, instanced once.
- The arbiter, response buffers and counters stay in the top of the block.

Test Plan:
- Single request, add: req0 add A=7 B=1 -> req_ready[0]=1 in the same cycle; next cycle rsp_valid[0]=1, out=1000, carry=0, ovf=1, zero=0; done_cnt[0]=1.
- Sub with borrow: req1 sub A=0 B=1 -> out=1111, carry=1, ovf=0. Also sub A=-8 B=1 -> out=0111, carry=0, ovf=1.
- Contention: both valid continuously with rsp_ready=1 -> grants 0,1,0,1,...; after 6 cycles done_cnt = 3/3.
- Backpressure: rsp_ready[0]=0 after the first result, both requesters valid -> slot 0 frozen, req_ready[0]=0, requester 1 granted every cycle. Raising rsp_ready[0] allows a drain-and-refill grant to requester 0 in that same cycle.
- Logic/compare ops: slt A=-1 B=1 -> out=0001; eq A=5 B=5 -> 0001; xor A=5 B=5 -> 0000 with zero=1; not A=0 -> 1111. All four have carry=ovf=0.
- Async reset asserted between grant and the response edge -> rsp_valid=0 immediately, counters 0; after release, first contended grant goes to requester 0.
